// File: rtl/mul8_compressor_pkg.sv
// Shared constants and elaboration-time column-height helpers for the 8x8 column compressor.
// MUL8_COMPRESSOR_PIPE_EN selects a carry-save pipeline register (LATENCY 2 instead of 1).
package mul8_compressor_pkg;

  localparam int NUM_COLS = 15;
  localparam int OUT_W    = 16;
  localparam int COL_HEIGHT [NUM_COLS] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};

`ifdef MUL8_COMPRESSOR_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

  // Height of column `col` after `stage` full-adder layers: each layer turns every bit
  // triple into one sum (same column) and one carry (next column); leftovers pass through.
  // Carries out of the top column are dropped since the true sum fits in OUT_W bits.
  function automatic int col_h(input int stage, input int col);
    int h [OUT_W];
    int n [OUT_W];
    for (int c = 0; c < OUT_W; c++) begin
      h[c] = 0;
      if (c < NUM_COLS) h[c] = COL_HEIGHT[c];
    end
    for (int s = 0; s < stage; s++) begin
      for (int c = 0; c < OUT_W; c++) begin
        n[c] = h[c] / 3 + h[c] % 3;
        if (c > 0) n[c] = n[c] + h[c-1] / 3;
      end
      h = n;
    end
    return h[col];
  endfunction

  // Bit offset of column `col` inside the flattened matrix of a stage.
  function automatic int col_off(input int stage, input int col);
    int o;
    o = 0;
    for (int c = 0; c < col; c++) o = o + col_h(stage, c);
    return o;
  endfunction

  function automatic int num_stages();
    int mx;
    for (int s = 0; s < 16; s++) begin
      mx = 0;
      for (int c = 0; c < OUT_W; c++)
        if (col_h(s, c) > mx) mx = col_h(s, c);
      if (mx <= 2) return s;
    end
    return 16;
  endfunction

endpackage

// File: rtl/full_adder.sv
// 3:2 counter used by every layer of the column reduction tree.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic ab_x;

  assign ab_x    = a_i ^ b_i;
  assign sum_o   = ab_x ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & ab_x);

endmodule

// File: rtl/mul8_column_compressor.sv
// Wallace-style reduction of the 8x8 partial-product matrix to two rows plus a 16-bit adder.
// MUL8_COMPRESSOR_PIPE_EN adds a carry-save register before the final adder (latency 2).
module mul8_column_compressor
  import mul8_compressor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [0:0] src0,
  input  logic [1:0] src1,
  input  logic [2:0] src2,
  input  logic [3:0] src3,
  input  logic [4:0] src4,
  input  logic [5:0] src5,
  input  logic [6:0] src6,
  input  logic [7:0] src7,
  input  logic [6:0] src8,
  input  logic [5:0] src9,
  input  logic [4:0] src10,
  input  logic [3:0] src11,
  input  logic [2:0] src12,
  input  logic [1:0] src13,
  input  logic [0:0] src14,
  output logic       dst0,
  output logic       dst1,
  output logic       dst2,
  output logic       dst3,
  output logic       dst4,
  output logic       dst5,
  output logic       dst6,
  output logic       dst7,
  output logic       dst8,
  output logic       dst9,
  output logic       dst10,
  output logic       dst11,
  output logic       dst12,
  output logic       dst13,
  output logic       dst14,
  output logic       dst15
);

  localparam int STAGES = num_stages();

  logic [OUT_W-1:0] row_a, row_b, sum_d, sum_q;

  // Each stage holds its matrix flattened column by column, column 0 at the LSB end.
  // Within a column the layout is: FA sums, pass-through bits, carries from the column below.
  for (genvar s = 0; s <= STAGES; s++) begin : g_st
    localparam int TOT = col_off(s, OUT_W);
    logic [TOT-1:0] v;

    if (s == 0) begin : g_in
      assign v = {src14, src13, src12, src11, src10, src9, src8, src7,
                  src6, src5, src4, src3, src2, src1, src0};
    end else begin : g_red
      for (genvar c = 0; c < OUT_W; c++) begin : g_col
        localparam int H   = col_h(s-1, c);
        localparam int NFA = H / 3;
        localparam int REM = H % 3;
        localparam int IB  = col_off(s-1, c);
        localparam int OB  = col_off(s, c);

        for (genvar f = 0; f < NFA; f++) begin : g_fa
          if (c < OUT_W-1) begin : g_c
            localparam int HN = col_h(s-1, c+1);
            localparam int CB = col_off(s, c+1) + HN / 3 + HN % 3;
            full_adder u_fa (
              .a_i    (g_st[s-1].v[IB+3*f]),
              .b_i    (g_st[s-1].v[IB+3*f+1]),
              .c_i    (g_st[s-1].v[IB+3*f+2]),
              .sum_o  (v[OB+f]),
              .carry_o(v[CB+f])
            );
          end else begin : g_top
            logic carry_drop;
            full_adder u_fa (
              .a_i    (g_st[s-1].v[IB+3*f]),
              .b_i    (g_st[s-1].v[IB+3*f+1]),
              .c_i    (g_st[s-1].v[IB+3*f+2]),
              .sum_o  (v[OB+f]),
              .carry_o(carry_drop)
            );
          end
        end

        for (genvar r = 0; r < REM; r++) begin : g_pass
          assign v[OB+NFA+r] = g_st[s-1].v[IB+3*NFA+r];
        end
      end
    end
  end

  for (genvar c = 0; c < OUT_W; c++) begin : g_rows
    localparam int H = col_h(STAGES, c);
    localparam int O = col_off(STAGES, c);
    if (H > 0) begin : g_a
      assign row_a[c] = g_st[STAGES].v[O];
    end else begin : g_a0
      assign row_a[c] = 1'b0;
    end
    if (H > 1) begin : g_b
      assign row_b[c] = g_st[STAGES].v[O+1];
    end else begin : g_b0
      assign row_b[c] = 1'b0;
    end
  end

`ifdef MUL8_COMPRESSOR_PIPE_EN
  logic [OUT_W-1:0] row_a_q, row_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_a_q <= '0;
      row_b_q <= '0;
    end else begin
      row_a_q <= row_a;
      row_b_q <= row_b;
    end
  end

  assign sum_d = row_a_q + row_b_q;
`else
  assign sum_d = row_a + row_b;
`endif

  // Carry out of bit 15 cannot occur: max product is 0xFE01.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign {dst15, dst14, dst13, dst12, dst11, dst10, dst9, dst8,
          dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0} = sum_q;

endmodule

// File: tb/tb_mul8_column_compressor.sv
// Scoreboard bench for mul8_column_compressor: stimulus pushes expected sums, a monitor pops them.
module tb_mul8_column_compressor;
  import mul8_compressor_pkg::*;

  localparam int H_TB [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};

  logic       clk, rst;
  logic [0:0] src0, src14;
  logic [1:0] src1, src13;
  logic [2:0] src2, src12;
  logic [3:0] src3, src11;
  logic [4:0] src4, src10;
  logic [5:0] src5, src9;
  logic [6:0] src6, src8;
  logic [7:0] src7;
  logic dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7;
  logic dst8, dst9, dst10, dst11, dst12, dst13, dst14, dst15;
  logic [15:0] dst_vec;

  mul8_column_compressor dut (
    .clk(clk), .rst(rst),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3), .src4(src4),
    .src5(src5), .src6(src6), .src7(src7), .src8(src8), .src9(src9),
    .src10(src10), .src11(src11), .src12(src12), .src13(src13), .src14(src14),
    .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3), .dst4(dst4),
    .dst5(dst5), .dst6(dst6), .dst7(dst7), .dst8(dst8), .dst9(dst9),
    .dst10(dst10), .dst11(dst11), .dst12(dst12), .dst13(dst13),
    .dst14(dst14), .dst15(dst15)
  );

  assign dst_vec = {dst15, dst14, dst13, dst12, dst11, dst10, dst9, dst8,
                    dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] col [15];
  logic [15:0] exp_q [$];
  logic issue;
  logic [LATENCY-1:0] sh;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask(input int i);
    logic [8:0] m;
    m = (9'd1 << H_TB[i]) - 9'd1;
    return m[7:0];
  endfunction

  function automatic int unsigned wpop();
    int unsigned s;
    s = 0;
    for (int i = 0; i < 15; i++) s += $countones(col[i]) << i;
    return s;
  endfunction

  task automatic clear_cols();
    for (int i = 0; i < 15; i++) col[i] = 8'h00;
  endtask

  task automatic ones_cols();
    for (int i = 0; i < 15; i++) col[i] = mask(i);
  endtask

  // Column i collects a[j]&b[k] for every j+k == i, in any order.
  task automatic build_pp(input logic [7:0] a, input logic [7:0] b);
    int cnt [15];
    for (int i = 0; i < 15; i++) begin col[i] = 8'h00; cnt[i] = 0; end
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++) begin
        col[j+k][cnt[j+k]] = a[j] & b[k];
        cnt[j+k]++;
      end
  endtask

  task automatic drive_cols();
    src0 = col[0][0:0];  src1 = col[1][1:0];  src2 = col[2][2:0];
    src3 = col[3][3:0];  src4 = col[4][4:0];  src5 = col[5][5:0];
    src6 = col[6][6:0];  src7 = col[7][7:0];  src8 = col[8][6:0];
    src9 = col[9][5:0];  src10 = col[10][4:0]; src11 = col[11][3:0];
    src12 = col[12][2:0]; src13 = col[13][1:0]; src14 = col[14][0:0];
  endtask

  task automatic issue_cols(input logic [15:0] e);
    drive_cols();
    issue = 1'b1;
    exp_q.push_back(e);
  endtask

  // Tracks which captured input sets have reached the output register.
  always @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= (sh << 1) | LATENCY'(issue);
  end

  always @(negedge clk) begin
    if (!rst && sh[LATENCY-1]) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: output 0x%0h with no expected entry", dst_vec);
      end else begin
        check("sb", {16'h0, dst_vec}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int k;
    logic [7:0] a, b;
    rst = 1'b1;
    issue = 1'b0;
    clear_cols();
    drive_cols();
    repeat (3) @(negedge clk);
    check("reset_state", {16'h0, dst_vec}, 32'h0);
    rst = 1'b0;

    // Directed patterns back to back, one per cycle
    clear_cols();               issue_cols(16'h0000);
    @(negedge clk); ones_cols(); issue_cols(16'hFE01);
    @(negedge clk); clear_cols(); col[7] = 8'hFF; issue_cols(16'h0400);
    @(negedge clk); build_pp(8'hFF, 8'h01); issue_cols(16'h00FF);
    @(negedge clk); build_pp(8'hAB, 8'hCD); issue_cols(16'h88EF);
    @(negedge clk); issue = 1'b0; clear_cols(); drive_cols();
    repeat (LATENCY + 2) @(negedge clk);

    // Latency measurement: count edges until the all-ones sum appears
    ones_cols(); drive_cols();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      k++;
      if (dst_vec == 16'hFE01) break;
    end
    check("latency", k, LATENCY);

    // Asynchronous reset mid-stream
    @(negedge clk); issue_cols(16'hFE01);
    @(negedge clk); issue = 1'b0;
    repeat (LATENCY + 1) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", {16'h0, dst_vec}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_hold", {16'h0, dst_vec}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    build_pp(8'hAB, 8'hCD); issue_cols(16'h88EF);

    // Random operand pairs via partial products
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      build_pp(a, b);
      issue_cols(16'(a * b));
    end

    // Random bit matrices against weighted popcount
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 15; i++) col[i] = 8'($urandom) & mask(i);
      issue_cols(16'(wpop()));
    end

    @(negedge clk); issue = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);
    check("drain", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul8_column_compressor.md
Name: mul8_column_compressor

Overview:
- Reduces the partial-product bit matrix of an 8x8 unsigned multiplier to one 16-bit binary sum.
- Input column i carries N_i bits of weight 2^i, with N = 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1 for i = 0..14.
- Output = sum over i of popcount(src_i) * 2^i, presented as 16 individual bit ports.
- Sits after the partial-product generator (or an input shift-register harness) in the multiplier datapath; output is registered.

Parameters:
- None. Column heights and output width are fixed constants (see Decomposition).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- src0  input  1  column 0 bits, weight 2^0
- src1  input  2  column 1 bits, weight 2^1
- src2  input  3  column 2 bits, weight 2^2
- src3  input  4  column 3 bits, weight 2^3
- src4  input  5  column 4 bits, weight 2^4
- src5  input  6  column 5 bits, weight 2^5
- src6  input  7  column 6 bits, weight 2^6
- src7  input  8  column 7 bits, weight 2^7
- src8  input  7  column 8 bits, weight 2^8
- src9  input  6  column 9 bits, weight 2^9
- src10  input  5  column 10 bits, weight 2^10
- src11  input  4  column 11 bits, weight 2^11
- src12  input  3  column 12 bits, weight 2^12
- src13  input  2  column 13 bits, weight 2^13
- src14  input  1  column 14 bits, weight 2^14
- dst0..dst15  output  1 each  result bit k of the 16-bit sum (dst0 = LSB)

Behaviour:
- Bit position within a column is irrelevant; only the per-column popcount matters.
- Reduction:
  - Dadda/Wallace tree of 3:2 full adders and 2:2 half adders, down to two rows.
  - Then a 16-bit carry-propagate adder.
  - Any correct reduction order is acceptable; the result must be exact.
- Width rule:
  - Maximum sum is 255*255 = 65025 (0xFE01), so 16 bits never overflow.
  - Carry out of bit 15 is provably 0; discard it without a check.
- Latency: 1 cycle. Result of inputs sampled at rising edge n appears on dst at edge n+1.
- Throughput: one new input set per cycle. No handshake, no valid signal, no stall.
- Reset:
  - rst=1 asynchronously clears all output registers; dst0..dst15 = 0 immediately.
  - While rst stays high, outputs remain 0.
  - On rst deassertion, the first edge captures the current inputs normally.
- Reset asserted mid-stream: in-flight result is lost, with no spurious output afterward.
- X/undriven inputs need not be handled specially.

Optional Feature:
- Macro: MUL8_COMPRESSOR_PIPE_EN
- Defined:
  - Adds a register stage holding the two-row carry-save result between the reduction tree and the final adder.
  - Latency becomes 2 cycles; throughput stays one per cycle.
  - The pipeline register also resets asynchronously to 0 on rst.
- Undefined: single output register only, latency 1.

Decomposition:
- Package mul8_compressor_pkg holds:
  - NUM_COLS = 15
  - OUT_W = 16
  - the COL_HEIGHT constant array {1,2,3,4,5,6,7,8,7,6,5,4,3,2,1}
  - LATENCY, resolved from the macro as 1 or 2
- One sub-module is natural: full_adder, a 3:2 counter with outputs sum and carry.
- Half adders may be inline logic.

Test Plan:
- All inputs 0 after reset release -> dst = 0x0000 after latency.
- All inputs all-ones -> dst = 0xFE01 (65025) after latency.
- src7 = 8'hFF, all others 0 -> sum 8*128 = 1024 -> only dst10 = 1.
- Partial products of a=0xFF, b=0x01 (column i = one set bit for i=0..7) -> dst = 0x00FF. Then a=0xAB, b=0xCD -> dst = 0x88EF, with back-to-back inputs producing a result every cycle.
- Assert rst asynchronously between clock edges while outputs are nonzero -> dst goes to 0 before the next edge. After release, the next result is correct.
- 10k random a,b with partial-product stimulus -> dst equals a*b; random bit matrices -> dst equals the weighted popcount sum. Run both with and without MUL8_COMPRESSOR_PIPE_EN and check the latency in each build.
